// File: rtl/key_state_tracker_if.sv
// PS/2 byte stream in, held-key state out, bundled between the byte receiver
// (master) and the key state tracker (slave).
interface key_state_tracker_if;
  logic [7:0] ps2_byte;
  logic       ps2_byte_valid;
  logic [7:0] key_pressed_data;
  logic       key_changed;

  modport master (
    output ps2_byte,
    output ps2_byte_valid,
    input  key_pressed_data,
    input  key_changed
  );

  modport slave (
    input  ps2_byte,
    input  ps2_byte_valid,
    output key_pressed_data,
    output key_changed
  );
endinterface

// File: rtl/key_state_tracker.sv
// Two-slot PS/2 held-key tracker with idle timeout.
// Optional macro EXT_KEY_FILTER_EN: E0-prefixed make/break bytes leave the slots untouched.
module key_state_tracker #(
  parameter int unsigned TIMEOUT = 50_000_000
) (
  input  logic                clk_50,
  input  logic                resetn,
  key_state_tracker_if.slave  kbd
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    s0_q, s0_d;
  logic [7:0]    s1_q, s1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q;
  logic          kc_q;

  function automatic logic is_ctrl(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ctrl = 1'b1;
      default:                                   is_ctrl = 1'b0;
    endcase
  endfunction

  // Returns {s0, s1}; a repeat of the newest key is typematic and changes nothing.
  function automatic logic [15:0] do_make(input logic [7:0] c, input logic [7:0] s0,
                                          input logic [7:0] s1);
    if (c == s0) begin
      do_make = {s0, s1};
    end else if (c == s1) begin
      do_make = {c, s0};
    end else begin
      do_make = {c, s0};
    end
  endfunction

  function automatic logic [15:0] do_break(input logic [7:0] c, input logic [7:0] s0,
                                           input logic [7:0] s1);
    if (c == s0) begin
      do_break = {s1, 8'h00};
    end else if (c == s1) begin
      do_break = {s0, 8'h00};
    end else begin
      do_break = {s0, s1};
    end
  endfunction

  // Next-state: byte decoding, slot updates and idle timeout.
  always_comb begin
    state_d = state_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    cnt_d   = cnt_q;
    if (kbd.ps2_byte_valid) begin
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (kbd.ps2_byte == 8'hF0) begin
            state_d = BRK;
          end else if (kbd.ps2_byte == 8'hE0) begin
            state_d = EXT;
          end else if (is_ctrl(kbd.ps2_byte)) begin
            state_d = IDLE;
          end else begin
            {s0_d, s1_d} = do_make(kbd.ps2_byte, s0_q, s1_q);
          end
        end
        BRK: begin
          state_d = IDLE;
          if (!is_ctrl(kbd.ps2_byte)) begin
            {s0_d, s1_d} = do_break(kbd.ps2_byte, s0_q, s1_q);
          end else begin
            s0_d = s0_q;
          end
        end
        EXT: begin
          if (kbd.ps2_byte == 8'hF0) begin
            state_d = EXT_BRK;
          end else begin
            state_d = IDLE;
`ifdef EXT_KEY_FILTER_EN
            s0_d = s0_q;
`else
            {s0_d, s1_d} = do_make(kbd.ps2_byte, s0_q, s1_q);
`endif
          end
        end
        EXT_BRK: begin
          state_d = IDLE;
`ifdef EXT_KEY_FILTER_EN
          s0_d = s0_q;
`else
          if (!is_ctrl(kbd.ps2_byte)) begin
            {s0_d, s1_d} = do_break(kbd.ps2_byte, s0_q, s1_q);
          end else begin
            s0_d = s0_q;
          end
`endif
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else if (cnt_q == CNT_LAST) begin
      s0_d    = 8'h00;
      s1_d    = 8'h00;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // State registers; key_changed trails the output change by one cycle.
  always_ff @(posedge clk_50) begin
    if (!resetn) begin
      state_q <= IDLE;
      s0_q    <= 8'h00;
      s1_q    <= 8'h00;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      kc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      cnt_q   <= cnt_d;
      pend_q  <= (s0_d != s0_q);
      kc_q    <= pend_q;
    end
  end

  assign kbd.key_pressed_data = s0_q;
  assign kbd.key_changed      = kc_q;

endmodule

// File: tb/tb_key_state_tracker.sv
// Self-checking bench for key_state_tracker (TIMEOUT=100): vector table plus timing/timeout sequences.
module tb_key_state_tracker;

  localparam int unsigned TO = 100;

  localparam logic [7:0] EXT_EXP =
`ifdef EXT_KEY_FILTER_EN
    8'h00;
`else
    8'h75;
`endif
  localparam int EXT_KC =
`ifdef EXT_KEY_FILTER_EN
    0;
`else
    2;
`endif

  localparam int OP_RST = 0;
  localparam int OP_BYTE = 1;
  localparam int OP_KC = 2;

  typedef struct {
    int         op;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   kc_count = 0;
  int   kc_base = 0;
  logic [7:0] exp_q[$];
  vec_t vecs[$];

  key_state_tracker_if kbd ();

  key_state_tracker #(.TIMEOUT(TO)) dut (
    .clk_50 (clk),
    .resetn (resetn),
    .kbd    (kbd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (kbd.key_changed === 1'b1) kc_count = kc_count + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: act=%02h req=%02h", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: act=%0d req=%0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    kbd.ps2_byte = 8'h1C;
    kbd.ps2_byte_valid = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    kbd.ps2_byte_valid = 1'b0;
    chk8("reset_kpd", kbd.key_pressed_data, 8'h00);
    chk8("reset_kc", {7'd0, kbd.key_changed}, 8'h00);
    kc_base = kc_count;
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] exp, input string nm);
    logic [7:0] e;
    @(negedge clk);
    kbd.ps2_byte = b;
    kbd.ps2_byte_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    kbd.ps2_byte_valid = 1'b0;
    e = exp_q.pop_front();
    chk8(nm, kbd.key_pressed_data, e);
  endtask

  function automatic void add(input int op, input logic [7:0] b, input logic [7:0] e);
    vec_t v;
    v.op = op;
    v.b = b;
    v.exp = e;
    vecs.push_back(v);
  endfunction

  initial begin
    kbd.ps2_byte = 8'h00;
    kbd.ps2_byte_valid = 1'b0;

    // typematic repeat
    add(OP_RST, 8'h00, 8'h00);
    add(OP_BYTE, 8'h1C, 8'h1C); add(OP_BYTE, 8'h1C, 8'h1C); add(OP_BYTE, 8'h1C, 8'h1C);
    add(OP_KC, 8'h00, 8'd1);
    // two keys, release newest
    add(OP_RST, 8'h00, 8'h00);
    add(OP_BYTE, 8'h1C, 8'h1C); add(OP_BYTE, 8'h23, 8'h23);
    add(OP_BYTE, 8'hF0, 8'h23); add(OP_BYTE, 8'h23, 8'h1C);
    add(OP_KC, 8'h00, 8'd3);
    // third key drops oldest
    add(OP_RST, 8'h00, 8'h00);
    add(OP_BYTE, 8'h1C, 8'h1C); add(OP_BYTE, 8'h23, 8'h23); add(OP_BYTE, 8'h3B, 8'h3B);
    add(OP_BYTE, 8'hF0, 8'h3B); add(OP_BYTE, 8'h1C, 8'h3B);
    add(OP_KC, 8'h00, 8'd3);
    add(OP_BYTE, 8'hF0, 8'h3B); add(OP_BYTE, 8'h55, 8'h3B);
    add(OP_BYTE, 8'hF0, 8'h3B); add(OP_BYTE, 8'h3B, 8'h23);
    add(OP_BYTE, 8'hF0, 8'h23); add(OP_BYTE, 8'h23, 8'h00);
    add(OP_KC, 8'h00, 8'd5);
    // extended key
    add(OP_RST, 8'h00, 8'h00);
    add(OP_BYTE, 8'hE0, 8'h00); add(OP_BYTE, 8'h75, EXT_EXP);
    add(OP_BYTE, 8'hE0, EXT_EXP); add(OP_BYTE, 8'hF0, EXT_EXP); add(OP_BYTE, 8'h75, 8'h00);
    add(OP_KC, 8'h00, EXT_KC[7:0]);
    // control bytes
    add(OP_RST, 8'h00, 8'h00);
    add(OP_BYTE, 8'hAA, 8'h00); add(OP_BYTE, 8'hFA, 8'h00); add(OP_BYTE, 8'h1C, 8'h1C);
    add(OP_BYTE, 8'hF0, 8'h1C); add(OP_BYTE, 8'hAA, 8'h1C); add(OP_BYTE, 8'h1C, 8'h1C);
    add(OP_BYTE, 8'hF0, 8'h1C); add(OP_BYTE, 8'h1C, 8'h00);
    add(OP_KC, 8'h00, 8'd2);
    // re-press older key, release of older key
    add(OP_RST, 8'h00, 8'h00);
    add(OP_BYTE, 8'h1C, 8'h1C); add(OP_BYTE, 8'h23, 8'h23); add(OP_BYTE, 8'h1C, 8'h1C);
    add(OP_BYTE, 8'hF0, 8'h1C); add(OP_BYTE, 8'h23, 8'h1C);
    add(OP_BYTE, 8'hF0, 8'h1C); add(OP_BYTE, 8'h1C, 8'h00);
    add(OP_KC, 8'h00, 8'd4);
    // reset in the middle of a break sequence
    add(OP_RST, 8'h00, 8'h00);
    add(OP_BYTE, 8'h1C, 8'h1C); add(OP_BYTE, 8'hF0, 8'h1C);
    add(OP_RST, 8'h00, 8'h00);
    add(OP_BYTE, 8'h1C, 8'h1C);
    add(OP_KC, 8'h00, 8'd1);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_RST:  do_reset();
        OP_BYTE: send(vecs[i].b, vecs[i].exp, $sformatf("vec%0d_kpd", i));
        OP_KC: begin
          tick(3);
          chk32($sformatf("vec%0d_kc_count", i), kc_count - kc_base, int'(vecs[i].exp));
        end
        default: chk32("bad_op", vecs[i].op, 0);
      endcase
    end

    // key_changed timing and valid-low ignore
    do_reset();
    send(8'h1C, 8'h1C, "tm_kpd");
    chk8("tm_kc_edge0", {7'd0, kbd.key_changed}, 8'h00);
    tick(1);
    chk8("tm_kc_edge1", {7'd0, kbd.key_changed}, 8'h01);
    tick(1);
    chk8("tm_kc_edge2", {7'd0, kbd.key_changed}, 8'h00);
    @(negedge clk);
    kbd.ps2_byte = 8'h23;
    kbd.ps2_byte_valid = 1'b0;
    tick(1);
    chk8("ignore_invalid", kbd.key_pressed_data, 8'h1C);
    send(8'h1C, 8'h1C, "typematic_kpd");
    tick(1);
    chk8("typematic_kc1", {7'd0, kbd.key_changed}, 8'h00);
    tick(1);
    chk8("typematic_kc2", {7'd0, kbd.key_changed}, 8'h00);

    // timeout fires exactly TO idle cycles after the last byte
    do_reset();
    send(8'h1C, 8'h1C, "to1_kpd");
    tick(TO - 1);
    chk8("to1_before", kbd.key_pressed_data, 8'h1C);
    tick(1);
    chk8("to1_clear", kbd.key_pressed_data, 8'h00);
    tick(3);
    chk32("to1_kc_count", kc_count - kc_base, 2);

    // byte one cycle before timeout reloads the counter
    do_reset();
    send(8'h1C, 8'h1C, "to2_kpd");
    tick(TO - 2);
    send(8'h1C, 8'h1C, "to2_late_kpd");
    tick(1);
    chk8("to2_no_clear", kbd.key_pressed_data, 8'h1C);
    tick(TO - 2);
    chk8("to2_before", kbd.key_pressed_data, 8'h1C);
    tick(1);
    chk8("to2_clear", kbd.key_pressed_data, 8'h00);

    // byte on the timeout edge wins
    do_reset();
    send(8'h1C, 8'h1C, "to3_kpd");
    tick(TO - 1);
    send(8'h23, 8'h23, "to3_collide");
    send(8'hF0, 8'h23, "to3_f0");
    send(8'h23, 8'h1C, "to3_s1_kept");

    chk32("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
